// File: rtl/aes_inv_round_sched.sv
// Iterative AES inverse-cipher round scheduler: walks rounds NUM_ROUNDS..0
// over one shared round datapath, fetching each round key from an external store.
//
// Ports:
//   Clk, Reset_n           clock, synchronous active-low reset
//   start, cipher_in       block request, sampled when ready=1
//   ready, busy, done      handshake / status (done is a one-cycle pulse)
//   plain_out              decrypted block, held until the next acceptance
//   key_idx, key_in        round-key store address and returned key
//   dp_state, dp_key       operands to the shared round datapath
//   dp_first, dp_last      whitening-round / final-round selects
//   dp_result              combinational datapath result
//   abort                  only when AES_SCHED_ABORT_EN is defined
//
// Build option: define AES_SCHED_ABORT_EN to add the abort input.
`timescale 1ns/1ps

module aes_inv_round_sched #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_LAT    = 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic [0:127] cipher_in,
`ifdef AES_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [0:127] plain_out,
    output logic [3:0]   key_idx,
    input  logic [0:127] key_in,
    output logic [0:127] dp_state,
    output logic [0:127] dp_key,
    output logic         dp_first,
    output logic         dp_last,
    input  logic [0:127] dp_result
);

    // Wait counter runs 0..KEY_LAT-1 while a key read is in flight.
    localparam int WW = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;

    localparam logic [3:0]    R_TOP = 4'(NUM_ROUNDS);
    localparam logic [WW-1:0] W_END = WW'(KEY_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_DONE
    } state_t;

    state_t        fsm_q, fsm_d;
    logic [3:0]    r_q, r_d;
    logic [3:0]    kidx_q, kidx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [0:127]  st_q, st_d;
    logic [0:127]  plain_q, plain_d;
    logic          abort_w;

`ifdef AES_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Round counter, key address, wait counter and data registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_q     <= R_TOP;
            kidx_q  <= R_TOP;
            wait_q  <= '0;
            st_q    <= '0;
            plain_q <= '0;
        end else begin
            r_q     <= r_d;
            kidx_q  <= kidx_d;
            wait_q  <= wait_d;
            st_q    <= st_d;
            plain_q <= plain_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        fsm_d   = fsm_q;
        r_d     = r_q;
        kidx_d  = kidx_q;
        wait_d  = wait_q;
        st_d    = st_q;
        plain_d = plain_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (fsm_q)
            S_IDLE, S_DONE: begin
                ready = 1'b1;
                done  = (fsm_q == S_DONE);
                if (start) begin
                    st_d   = cipher_in;
                    r_d    = R_TOP;
                    kidx_d = R_TOP;
                    wait_d = '0;
                    fsm_d  = S_FETCH;
                end else begin
                    fsm_d = S_IDLE;
                end
            end

            S_FETCH: begin
                busy = 1'b1;
                if (abort_w) begin
                    st_d   = '0;
                    r_d    = R_TOP;
                    kidx_d = R_TOP;
                    wait_d = '0;
                    fsm_d  = S_IDLE;
                end else if (wait_q == W_END) begin
                    fsm_d = S_APPLY;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_APPLY: begin
                busy = 1'b1;
                if (abort_w) begin
                    // Abort wins over the capture of this round.
                    st_d   = '0;
                    r_d    = R_TOP;
                    kidx_d = R_TOP;
                    wait_d = '0;
                    fsm_d  = S_IDLE;
                end else begin
                    st_d = dp_result;
                    if (r_q == 4'd0) begin
                        plain_d = dp_result;
                        fsm_d   = S_DONE;
                    end else begin
                        // Next key address issues now so the read
                        // overlaps the following FETCH cycles.
                        r_d    = r_q - 4'd1;
                        kidx_d = r_q - 4'd1;
                        wait_d = '0;
                        fsm_d  = S_FETCH;
                    end
                end
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Round selects only mean something while a round is in progress.
    assign dp_first  = busy && (r_q == R_TOP);
    assign dp_last   = busy && (r_q == 4'd0);

    assign dp_state  = st_q;
    assign dp_key    = key_in;
    assign plain_out = plain_q;
    assign key_idx   = kidx_q;

endmodule

// File: tb/tb_aes_inv_round_sched.sv
// Scoreboard bench for aes_inv_round_sched: a real AES inverse round and
// key store around one instance, a mock XOR datapath around a 14-round one.
`timescale 1ns/1ps

module tb_aes_inv_round_sched;

    localparam int LAT1 = 23;
    localparam int LAT2 = 61;

    typedef struct {
        logic [0:127] pt;
        int           due;
    } exp_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    exp_t q1[$];
    exp_t q2[$];

    logic         Reset_n;
    logic         start;
    logic [0:127] cipher_in;
    logic         abort;
    logic         ready, busy, done;
    logic [0:127] plain_out;
    logic [3:0]   key_idx;
    logic [0:127] key_in;
    logic [0:127] dp_state, dp_key, dp_result;
    logic         dp_first, dp_last;

    logic         start2;
    logic [0:127] cipher2;
    logic         ready2, busy2, done2;
    logic [0:127] plain2;
    logic [3:0]   key_idx2;
    logic [0:127] key_in2, kp1, kp2;
    logic [0:127] dp_state2, dp_key2, dp_result2;
    logic         dp_first2, dp_last2;

    aes_inv_round_sched #(.NUM_ROUNDS(10), .KEY_LAT(1)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .cipher_in (cipher_in),
`ifdef AES_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .plain_out (plain_out),
        .key_idx   (key_idx),
        .key_in    (key_in),
        .dp_state  (dp_state),
        .dp_key    (dp_key),
        .dp_first  (dp_first),
        .dp_last   (dp_last),
        .dp_result (dp_result)
    );

    aes_inv_round_sched #(.NUM_ROUNDS(14), .KEY_LAT(3)) dut2 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start2),
        .cipher_in (cipher2),
`ifdef AES_SCHED_ABORT_EN
        .abort     (1'b0),
`endif
        .ready     (ready2),
        .busy      (busy2),
        .done      (done2),
        .plain_out (plain2),
        .key_idx   (key_idx2),
        .key_in    (key_in2),
        .dp_state  (dp_state2),
        .dp_key    (dp_key2),
        .dp_first  (dp_first2),
        .dp_last   (dp_last2),
        .dp_result (dp_result2)
    );

    // ---------------- AES reference pieces ----------------
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [0:127] rk    [16];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] mcoef(input int k);
        case (k)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // InvShiftRows followed by InvSubBytes.
    function automatic logic [0:127] inv_ss(input logic [0:127] b);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = isbox[b[8*(4*((c-r+4)%4)+r) +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] inv_mix(input logic [0:127] b);
        logic [0:127] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(mcoef((j-r+4)%4), b[8*(4*c+j) +: 8]);
                o[8*(4*c+r) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [0:127] ref_dec(input logic [0:127] c);
        logic [0:127] s;
        s = c ^ rk[10];
        for (int r = 9; r >= 1; r--) s = inv_mix(inv_ss(s) ^ rk[r]);
        return inv_ss(s) ^ rk[0];
    endfunction

    // Shared round datapath and 1-cycle key store around dut.
    always_comb begin
        if (dp_first)     dp_result = dp_state ^ dp_key;
        else if (dp_last) dp_result = inv_ss(dp_state) ^ dp_key;
        else              dp_result = inv_mix(inv_ss(dp_state) ^ dp_key);
    end

    always @(posedge Clk) key_in <= rk[key_idx];

    // Mock around dut2: key(r) = r replicated, 3-cycle read, XOR datapath.
    assign dp_result2 = dp_state2 ^ dp_key2;
    always @(posedge Clk) begin
        kp1     <= {32{key_idx2}};
        kp2     <= kp1;
        key_in2 <= kp2;
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    logic [0:127] last1 = '0;
    bit           armed = 1'b0;
    int           nf = 0;
    int           nl = 0;

    always @(negedge Clk) begin
        exp_t e;
        if (armed) begin
            if (done) begin
                if (q1.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("plain_out", plain_out, e.pt);
                    chk("done_cycle", 128'(cyc), 128'(e.due));
                    last1 = e.pt;
                end
            end else begin
                chk("plain_hold", plain_out, last1);
            end
        end
        if (!Reset_n) begin
            last1 = '0;
            armed = 1'b1;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (armed) begin
            if (busy2) begin
                if (dp_first2) begin
                    nf++;
                    chk("first_idx", 128'(key_idx2), 128'(14));
                end
                if (dp_last2) begin
                    nl++;
                    chk("last_idx", 128'(key_idx2), 128'(0));
                end
            end else begin
                chk("flags_idle", 128'({dp_first2, dp_last2}), 128'(0));
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done2: done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q2.pop_front();
                    chk("plain2", plain2, e.pt);
                    chk("done2_cycle", 128'(cyc), 128'(e.due));
                    chk("first_cycles", 128'(nf), 128'(4));
                    chk("last_cycles", 128'(nl), 128'(4));
                end
                nf = 0;
                nl = 0;
            end
        end
    end

    // Caller is positioned just after a rising edge; returns in cycle 1.
    task automatic send(input logic [0:127] c, input logic [0:127] pt);
        exp_t e;
        start     = 1'b1;
        cipher_in = c;
        @(negedge Clk);
        chk("send_ready", 128'(ready), 128'(1));
        if (ready) begin
            e.pt  = pt;
            e.due = cyc + LAT1;
            q1.push_back(e);
        end
        @(posedge Clk);
        #1;
        start     = 1'b0;
        cipher_in = ~c;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [0:127] key, ct, pt, pt2, pt3;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   inv, s, rc;
    exp_t         e2;

    initial begin
        Reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cipher_in = '0;
        start2    = 1'b0;
        cipher2   = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end

        key = 128'h000102030405060708090a0b0c0d0e0f;
        ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt  = 128'h00112233445566778899aabbccddeeff;
        rc  = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[i] = key[32*i +: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                        ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end
                w[i] = w[i-4] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        pt2 = ref_dec(pt);
        pt3 = ref_dec(~pt);

        // Reset values.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_plain", plain_out, 128'(0));
        chk("rst_state", dp_state, 128'(0));
        chk("rst_key_idx", 128'(key_idx), 128'(10));
        chk("rst_flags", 128'({dp_first, dp_last}), 128'(0));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(2);

        // FIPS-197 C.1 with key address sequence.
        send(ct, pt);
        for (int k = 1; k <= 22; k++) begin
            @(negedge Clk);
            chk("key_idx_seq", 128'(key_idx), 128'(10 - (k - 1) / 2));
        end
        idle(3);

        // Back-to-back: second start lands in the DONE cycle.
        send(ct, pt);
        idle(22);
        send(pt, pt2);
        idle(26);

        // Starts while busy are ignored.
        send(~pt, pt3);
        idle(4);
        start     = 1'b1;
        cipher_in = 128'hdeadbeef_00000000_cafef00d_12345678;
        idle(1);
        start     = 1'b0;
        idle(6);
        start     = 1'b1;
        cipher_in = 128'h0;
        idle(1);
        start     = 1'b0;
        idle(15);

        // Reset in cycle 9 aborts silently.
        send(ct, pt);
        idle(8);
        Reset_n = 1'b0;
        q1.delete();
        idle(1);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("mid_rst_ready", 128'(ready), 128'(1));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_key_idx", 128'(key_idx), 128'(10));
        chk("mid_rst_plain", plain_out, 128'(0));
        idle(30);

        // 14 rounds, 3-cycle key latency on dut2.
        start2  = 1'b1;
        cipher2 = 128'h0123456789abcdef_fedcba9876543210;
        @(negedge Clk);
        chk("send2_ready", 128'(ready2), 128'(1));
        e2.pt  = 128'hfedcba9876543210_0123456789abcdef;
        e2.due = cyc + LAT2;
        q2.push_back(e2);
        @(posedge Clk);
        #1;
        start2  = 1'b0;
        cipher2 = '0;
        idle(64);

`ifdef AES_SCHED_ABORT_EN
        send(ct, pt);
        idle(25);
        send(pt, pt2);
        idle(6);
        abort = 1'b1;
        q1.delete();
        idle(1);
        abort = 1'b0;
        @(negedge Clk);
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_key_idx", 128'(key_idx), 128'(10));
        chk("abort_state", dp_state, 128'(0));
        idle(30);
        send(pt, pt2);
        idle(26);
`endif

        idle(4);
        chk("pending_done", 128'(q1.size()), 128'(0));
        chk("pending_done2", 128'(q2.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
